// File: rtl/popcount_frame_acc.sv
// Frames the per-nibble ones-count stream: sums FRAME_LEN accepted counts,
// tracks the peak and an error flag, then holds the result on a valid/ready port.
module popcount_frame_acc #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ACC_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_count,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [2:0]       out_peak,
  output logic             out_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]       peak_q, peak_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [2:0]       clamped_s;
  logic [SUM_W-1:0] sum_s;

  function automatic logic [2:0] clamp_count(input logic [2:0] c);
    if (c > 3'd4) begin
      return 3'd4;
    end else begin
      return c;
    end
  endfunction

  function automatic logic is_illegal(input logic [2:0] c);
    return (c > 3'd4);
  endfunction

  assign clamped_s = clamp_count(in_count);
  assign sum_s     = {1'b0, acc_q} + {{(SUM_W-3){1'b0}}, clamped_s};

  // Handshake signals depend only on state and reset.
  assign in_ready  = (state_q == ST_ACCUM) && !rst;
  assign out_valid = (state_q == ST_HOLD) && !rst;
  assign out_total = acc_q;
  assign out_peak  = peak_q;
  assign out_err   = err_q;

  // Next-state and accumulator update logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    peak_d     = peak_q;
    err_d      = err_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          // Saturate rather than wrap when ACC_W is undersized.
          if (sum_s > {1'b0, ACC_MAX}) begin
            acc_d = ACC_MAX;
            err_d = 1'b1;
          end else begin
            acc_d = sum_s[ACC_W-1:0];
          end
          if (is_illegal(in_count)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_d;
          end
          if (clamped_s > peak_q) begin
            peak_d = clamped_s;
          end else begin
            peak_d = peak_q;
          end
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = {CNT_W{1'b0}};
            state_d    = ST_HOLD;
          end else begin
            beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = {ACC_W{1'b0}};
          peak_d  = 3'd0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d    = ST_ACCUM;
        acc_d      = {ACC_W{1'b0}};
        peak_d     = 3'd0;
        err_d      = 1'b0;
        beat_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACCUM;
      acc_q      <= {ACC_W{1'b0}};
      peak_q     <= 3'd0;
      err_q      <= 1'b0;
      beat_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      peak_q     <= peak_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Randomized and directed bench for popcount_frame_acc against a frame-level model;
// a second instance with a narrow accumulator exercises saturation.
module tb_popcount_frame_acc;

  localparam int FL  = 16;
  localparam int AW  = 7;
  localparam int AWS = 5;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [2:0] in_count;

  logic           in_ready, out_valid, out_err;
  logic [AW-1:0]  out_total;
  logic [2:0]     out_peak;
  logic           s_in_ready, s_out_valid, s_out_err;
  logic [AWS-1:0] s_out_total;
  logic [2:0]     s_out_peak;

  popcount_frame_acc #(.FRAME_LEN(FL), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_peak(out_peak), .out_err(out_err)
  );

  popcount_frame_acc #(.FRAME_LEN(FL), .ACC_W(AWS)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_total(s_out_total), .out_peak(s_out_peak), .out_err(s_out_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the frame so far is a list of accepted counts.
  int  m_beats[$];
  bit  m_bad;
  bit  m_hold;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_sum();
    int s = 0;
    foreach (m_beats[i]) s += m_beats[i];
    return s;
  endfunction

  function automatic int frame_peak();
    int p = 0;
    foreach (m_beats[i]) if (m_beats[i] > p) p = m_beats[i];
    return p;
  endfunction

  function automatic int sat(input int s, input int w);
    int mx = (1 << w) - 1;
    return (s > mx) ? mx : s;
  endfunction

  // Apply one cycle of inputs, check the DUTs before the edge, advance model and clock.
  task automatic cycle(input bit v, input int c, input bit ordy, input bit r);
    int cl;
    in_valid = v; in_count = c[2:0]; out_ready = ordy; rst = r;
    #1;
    check_val("in_ready", in_ready, !r && !m_hold);
    check_val("out_valid", out_valid, !r && m_hold);
    check_val("total", out_total, sat(frame_sum(), AW));
    check_val("peak", out_peak, frame_peak());
    check_val("err", out_err, m_bad || frame_sum() > (1 << AW) - 1);
    check_val("sat_total", s_out_total, sat(frame_sum(), AWS));
    check_val("sat_err", s_out_err, m_bad || frame_sum() > (1 << AWS) - 1);
    check_val("sat_valid", s_out_valid, !r && m_hold);
    cl = (c > 4) ? 4 : c;
    if (r) begin
      m_beats.delete(); m_bad = 1'b0; m_hold = 1'b0;
    end else if (!m_hold) begin
      if (v) begin
        m_beats.push_back(cl);
        if (c > 4) m_bad = 1'b1;
        if (m_beats.size() == FL) m_hold = 1'b1;
      end
    end else if (ordy) begin
      m_beats.delete(); m_bad = 1'b0; m_hold = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_frame(input int total, input int peak, input int err);
    check_val("frame_valid", out_valid, 1);
    check_val("frame_total", out_total, total);
    check_val("frame_peak", out_peak, peak);
    check_val("frame_err", out_err, err);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_count = 3'd0; out_ready = 1'b0;
    m_bad = 1'b0; m_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_total", out_total, 0);
    check_val("rst_peak", out_peak, 0);
    check_val("rst_err", out_err, 0);

    // 16 beats of 1, then handshake in the first HOLD cycle.
    repeat (FL) cycle(1'b1, 1, 1'b1, 1'b0);
    expect_frame(16, 1, 0);
    cycle(1'b1, 1, 1'b1, 1'b0);
    check_val("ready_back", in_ready, 1);

    repeat (FL) cycle(1'b1, 4, 1'b1, 1'b0);
    expect_frame(64, 4, 0);
    check_val("sat64_total", s_out_total, 31);
    check_val("sat64_err", s_out_err, 1);
    cycle(1'b0, 0, 1'b1, 1'b0);

    for (int i = 0; i < FL; i++) cycle(1'b1, i % 4, 1'b1, 1'b0);
    expect_frame(24, 3, 0);
    cycle(1'b0, 0, 1'b1, 1'b0);

    for (int i = 0; i < FL; i++) cycle(1'b1, (i == 2) ? 7 : 0, 1'b1, 1'b0);
    expect_frame(4, 4, 1);
    cycle(1'b0, 0, 1'b1, 1'b0);
    repeat (FL) cycle(1'b1, 0, 1'b1, 1'b0);
    expect_frame(0, 0, 0);
    cycle(1'b0, 0, 1'b1, 1'b0);

    // Backpressure while upstream keeps offering beats of 3.
    repeat (FL) cycle(1'b1, 2, 1'b0, 1'b0);
    expect_frame(32, 2, 0);
    repeat (5) cycle(1'b1, 3, 1'b0, 1'b0);
    expect_frame(32, 2, 0);
    cycle(1'b1, 3, 1'b1, 1'b0);
    repeat (FL) cycle(1'b1, 1, 1'b0, 1'b0);
    expect_frame(16, 1, 0);
    cycle(1'b0, 0, 1'b1, 1'b0);

    // Sparse input: a beat every other cycle.
    for (int i = 0; i < 2 * FL; i++) cycle(i % 2 == 0, 2, 1'b0, 1'b0);
    expect_frame(32, 2, 0);
    cycle(1'b0, 0, 1'b1, 1'b0);

    // Reset mid-frame discards the partial sum.
    repeat (7) cycle(1'b1, 4, 1'b1, 1'b0);
    cycle(1'b1, 4, 1'b1, 1'b1);
    repeat (FL) cycle(1'b1, 1, 1'b0, 1'b0);
    expect_frame(16, 1, 0);

    // Reset during HOLD drops the result without a handshake.
    cycle(1'b1, 3, 1'b1, 1'b1);
    check_val("hold_rst_valid", out_valid, 0);
    check_val("hold_rst_total", out_total, 0);
    cycle(1'b0, 0, 1'b0, 1'b0);

    // Randomized traffic with occasional illegal counts and resets.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
